// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver (scan code set 2) that keeps held/released flags
// for the W, S, O and K keys, for use by the paddle controller.
// Ports:
//   iVGA_CLK     system clock, all logic on posedge
//   iRST_n       asynchronous active-low reset
//   iPS2_CLK     raw keyboard clock (async, idle high)
//   iPS2_DAT     raw keyboard data  (async, idle high)
//   oW/oS/oO/oK  key-held level flags, 1 = held
//   oScan_valid  one-cycle pulse: good frame received
//   oScan_code   data byte of the last good frame
//   oFrame_err   one-cycle pulse: bad start/stop, parity error or timeout
module ps2_key_tracker #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  CODE_W      = 8'h1D,
  parameter logic [7:0]  CODE_S      = 8'h1B,
  parameter logic [7:0]  CODE_O      = 8'h44,
  parameter logic [7:0]  CODE_K      = 8'h42
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       oW,
  output logic       oS,
  output logic       oO,
  output logic       oK,
  output logic       oScan_valid,
  output logic [7:0] oScan_code,
  output logic       oFrame_err
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          clk_sync_q, clk_sync_d;
  logic [1:0]          dat_sync_q, dat_sync_d;
  logic                filt_clk_q, filt_clk_d;
  logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                brk_q, brk_d;
  logic                ext_q, ext_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [7:0]          code_q, code_d;
  logic                w_q, w_d, s_q, s_d, o_q, o_d, k_q, k_d;
  logic                fall_c;
  logic                dat_c;

  // State register
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      w_q        <= 1'b0;
      s_q        <= 1'b0;
      o_q        <= 1'b0;
      k_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      code_q     <= code_d;
      w_q        <= w_d;
      s_q        <= s_d;
      o_q        <= o_d;
      k_q        <= k_d;
    end
  end

  // Synchroniser, clock filter, frame FSM and key decode
  always_comb begin
    clk_sync_d = {clk_sync_q[0], iPS2_CLK};
    dat_sync_d = {dat_sync_q[0], iPS2_DAT};
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    w_d        = w_q;
    s_d        = s_q;
    o_d        = o_q;
    k_d        = k_q;
    dat_c      = dat_sync_q[1];

    // Filtered clock follows the synced clock only after FILTER_LEN differing cycles
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end
    fall_c = filt_clk_q & ~filt_clk_d;

    // Idle-time counter restarts on every edge and is held in IDLE
    if (fall_c || state_q == IDLE) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (fall_c) begin
      case (state_q)
        IDLE: begin
          if (!dat_c) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {dat_c, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_c;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (dat_c && (^{shift_q, par_q})) begin
            valid_d = 1'b1;
            code_d  = shift_q;
            if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else begin
              if (!ext_q) begin
                if (shift_q == CODE_W) w_d = ~brk_q;
                if (shift_q == CODE_S) s_d = ~brk_q;
                if (shift_q == CODE_O) o_d = ~brk_q;
                if (shift_q == CODE_K) k_d = ~brk_q;
              end
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      // Stalled frame: abandon it and drop any half-received prefix
      state_d  = IDLE;
      err_d    = 1'b1;
      brk_d    = 1'b0;
      ext_d    = 1'b0;
      to_cnt_d = '0;
    end
  end

  assign oW          = w_q;
  assign oS          = s_q;
  assign oO          = o_q;
  assign oK          = k_q;
  assign oScan_valid = valid_q;
  assign oScan_code  = code_q;
  assign oFrame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       o_w, o_s, o_o, o_k;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int both_cnt = 0;

  ps2_key_tracker dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .iPS2_CLK    (ps2_clk),
    .iPS2_DAT    (ps2_dat),
    .oW          (o_w),
    .oS          (o_s),
    .oO          (o_o),
    .oK          (o_k),
    .oScan_valid (scan_valid),
    .oScan_code  (scan_code),
    .oFrame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_valid) vcnt++;
      if (frame_err) ecnt++;
      if (scan_valid && frame_err) both_cnt++;
    end
  end

  typedef struct {
    logic [7:0] code;
    bit         flip_par;
    bit         bad_stop;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_code;
    logic [3:0] exp_flags;  // {W,S,O,K}
  } vec_t;

  vec_t vecs[22];

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {19'd0, o_w, o_s, o_o, o_k, scan_valid, frame_err, scan_code}, 32'd0);
  endtask

  // One PS/2 bit: data set while the clock is high, then a 20-cycle low phase
  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(12);
    end else begin
      wait_cyc(20);
    end
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip_par, input bit bad_stop,
                            input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
    send_bit((~^code) ^ flip_par, glitch);
    send_bit(~bad_stop, glitch);
    ps2_dat = 1'b1;
    wait_cyc(20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_cyc(4);
    check_zero("in_reset");
    rst_n = 1'b1;
    wait_cyc(20);
    check_zero("after_reset");
  endtask

  initial begin
    int v0, e0;
    vecs[0]  = '{8'h1D, 0, 0, 1, 0, 8'h1D, 4'b1000};
    vecs[1]  = '{8'h1D, 0, 0, 1, 0, 8'h1D, 4'b1000};
    vecs[2]  = '{8'hF0, 0, 0, 1, 0, 8'hF0, 4'b1000};
    vecs[3]  = '{8'h1D, 0, 0, 1, 0, 8'h1D, 4'b0000};
    vecs[4]  = '{8'h1D, 0, 0, 1, 0, 8'h1D, 4'b1000};
    vecs[5]  = '{8'hE0, 0, 0, 1, 0, 8'hE0, 4'b1000};
    vecs[6]  = '{8'hF0, 0, 0, 1, 0, 8'hF0, 4'b1000};
    vecs[7]  = '{8'h1D, 0, 0, 1, 0, 8'h1D, 4'b1000};
    vecs[8]  = '{8'h1B, 0, 0, 1, 0, 8'h1B, 4'b1100};
    vecs[9]  = '{8'h44, 1, 0, 0, 1, 8'h1B, 4'b1100};
    vecs[10] = '{8'h44, 0, 0, 1, 0, 8'h44, 4'b1110};
    vecs[11] = '{8'h42, 0, 0, 1, 0, 8'h42, 4'b1111};
    vecs[12] = '{8'hF0, 0, 0, 1, 0, 8'hF0, 4'b1111};
    vecs[13] = '{8'h1B, 0, 0, 1, 0, 8'h1B, 4'b1011};
    vecs[14] = '{8'h42, 0, 1, 0, 1, 8'h1B, 4'b1011};
    vecs[15] = '{8'hF0, 1, 0, 0, 1, 8'h1B, 4'b1011};
    vecs[16] = '{8'h44, 0, 0, 1, 0, 8'h44, 4'b1011};
    vecs[17] = '{8'hF0, 0, 0, 1, 0, 8'hF0, 4'b1011};
    vecs[18] = '{8'h42, 0, 0, 1, 0, 8'h42, 4'b1010};
    vecs[19] = '{8'hF0, 0, 0, 1, 0, 8'hF0, 4'b1010};
    vecs[20] = '{8'h44, 0, 0, 1, 0, 8'h44, 4'b1000};
    vecs[21] = '{8'h5A, 0, 0, 1, 0, 8'h5A, 4'b1000};

    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(5);
    check_zero("reset_state");
    rst_n = 1'b1;
    wait_cyc(20);
    check_zero("post_reset_idle");

    // Short clock glitches while idle must not produce edges
    v0 = vcnt; e0 = ecnt;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    check("glitch_idle_valid", 32'(vcnt - v0), 32'd0);
    check("glitch_idle_err", 32'(ecnt - e0), 32'd0);

    // Break prefix, then a frame that stalls after 4 data bits
    send_frame(8'hF0, 0, 0, 0);
    check("tmo_prefix_code", 32'(scan_code), 32'hF0);
    e0 = ecnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    wait_cyc(40000);
    check("tmo_not_yet", 32'(ecnt - e0), 32'd0);
    wait_cyc(10100);
    check("tmo_err", 32'(ecnt - e0), 32'd1);
    // Prefix must have been cleared, so 42 is a make, not a break
    send_frame(8'h42, 0, 0, 0);
    check("tmo_then_k", {28'd0, o_w, o_s, o_o, o_k}, 32'b0001);
    check("tmo_then_code", 32'(scan_code), 32'h42);

    // Reset in the middle of a frame
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    do_reset();
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1B, 0, 0, 1);
    check("rst_mid_valid", 32'(vcnt - v0), 32'd1);
    check("rst_mid_err", 32'(ecnt - e0), 32'd0);
    check("rst_mid_code", 32'(scan_code), 32'h1B);
    check("rst_mid_flags", {28'd0, o_w, o_s, o_o, o_k}, 32'b0100);
    do_reset();

    for (int n = 0; n < 22; n++) begin
      v0 = vcnt; e0 = ecnt;
      send_frame(vecs[n].code, vecs[n].flip_par, vecs[n].bad_stop, 0);
      check($sformatf("vec%0d_valid", n), 32'(vcnt - v0), 32'(vecs[n].exp_v));
      check($sformatf("vec%0d_err", n), 32'(ecnt - e0), 32'(vecs[n].exp_e));
      check($sformatf("vec%0d_code", n), 32'(scan_code), 32'(vecs[n].exp_code));
      check($sformatf("vec%0d_flags", n), {28'd0, o_w, o_s, o_o, o_k}, 32'(vecs[n].exp_flags));
    end

    check("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
